// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch/decode instruction buffer.
// An entry holds the instruction word, its PC and its PC+4 link value.
package pipeline_pkg;

  localparam int INSN_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [INSN_W-1:0] NOP_INSN = 32'hD503201F;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_link;
  } if_id_entry_t;

  // Value presented to decode while the buffer holds nothing.
  function automatic if_id_entry_t idle_entry();
    if_id_entry_t e;
    e.insn    = NOP_INSN;
    e.pc      = {ADDR_W{1'b0}};
    e.pc_link = {ADDR_W{1'b0}};
    return e;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the instruction buffer.
// master = fetch/decode environment, slave = the queue itself.
interface if_id_queue_if
  import pipeline_pkg::*;
#(
  parameter int PTR_W = 2
);

  logic              in_valid;
  logic [INSN_W-1:0] in_instruction;
  logic [ADDR_W-1:0] in_pc;
  logic [ADDR_W-1:0] in_pc_link;
  logic              fetch_stall;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [INSN_W-1:0] out_instruction;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_link;
  logic [PTR_W:0]    count;

  modport master (
    output in_valid, in_instruction, in_pc, in_pc_link, flush, out_ready,
    input  fetch_stall, out_valid, out_instruction, out_pc, out_pc_link, count
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, in_pc_link, flush, out_ready,
    output fetch_stall, out_valid, out_instruction, out_pc, out_pc_link, count
  );

endinterface

// File: rtl/if_id_queue_wrap_ptr.sv
// PTR_W-bit circular pointer; clr has priority over inc and wraps DEPTH-1 -> 0.
module wrap_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] ptr_r;

  // Pointer register: reset and clear both return to slot 0.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + PTR_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/if_id_queue.sv
// In-order instruction buffer between fetch and decode with flush on redirect.
// Head entry is read straight out of storage; an empty buffer shows a NOP.
module if_id_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clock,
  input  logic          reset,
  if_id_queue_if.slave  bus
);

  localparam logic [PTR_W:0] CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

  if_id_entry_t     mem_r [DEPTH];
  if_id_entry_t     in_entry_s;
  if_id_entry_t     head_s;
  logic [PTR_W:0]   count_r;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             clr_s;

  // Handshake decode from the registered occupancy.
  always_comb begin
    full_s     = (count_r == CNT_DEPTH);
    empty_s    = (count_r == {(PTR_W+1){1'b0}});
    push_s     = bus.in_valid & ~full_s;
    pop_s      = ~empty_s & bus.out_ready;
    clr_s      = bus.flush;
    in_entry_s = '{insn: bus.in_instruction, pc: bus.in_pc, pc_link: bus.in_pc_link};
  end

  wrap_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (clr_s),
    .inc   (push_s),
    .ptr   (wr_ptr_s)
  );

  wrap_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clr   (clr_s),
    .inc   (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Occupancy: a simultaneous push and pop cancel out.
  always_ff @(posedge clock) begin
    if (reset || clr_s) begin
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; the array itself carries no reset.
  always_ff @(posedge clock) begin
    if (push_s && !clr_s && !reset) begin
      mem_r[wr_ptr_s] <= in_entry_s;
    end
  end

  // Head presentation, substituting the idle entry when empty.
  always_comb begin
    if (empty_s) begin
      head_s = idle_entry();
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  assign bus.fetch_stall     = full_s;
  assign bus.out_valid       = ~empty_s;
  assign bus.out_instruction = head_s.insn;
  assign bus.out_pc          = head_s.pc;
  assign bus.out_pc_link     = head_s.pc_link;
  assign bus.count           = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the buffer.
module tb_if_id_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  if_id_queue_if #(.PTR_W(PTR_W)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  if_id_entry_t mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the model's view of the buffer.
  task automatic compare_model();
    if_id_entry_t h;
    h = (mq.size() != 0) ? mq[0] : idle_entry();
    check("model_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    check("model_insn",  64'(bus.out_instruction), 64'(h.insn));
    check("model_pc",    bus.out_pc, h.pc);
    check("model_link",  bus.out_pc_link, h.pc_link);
    check("model_count", 64'(bus.count), 64'(mq.size()));
    check("model_stall", 64'(bus.fetch_stall), 64'(mq.size() == DEPTH));
  endtask

  // One clock: drive inputs, check at negedge, advance model with the edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] insn, input logic [63:0] pc,
                       input logic ordy);
    bit do_clr, do_pop, do_push;
    if_id_entry_t e;
    reset              = rst;
    bus.flush          = fl;
    bus.in_valid       = iv;
    bus.in_instruction = insn;
    bus.in_pc          = pc;
    bus.in_pc_link     = pc + 64'd4;
    bus.out_ready      = ordy;
    e = '{insn: insn, pc: pc, pc_link: pc + 64'd4};
    @(negedge clock);
    compare_model();
    do_clr  = rst || fl;
    do_pop  = !do_clr && ordy && (mq.size() != 0);
    do_push = !do_clr && iv && (mq.size() < DEPTH);
    @(posedge clock);
    if (do_clr) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_instruction = 32'h0;
    bus.in_pc          = 64'h0;
    bus.in_pc_link     = 64'h0;
    bus.out_ready      = 1'b0;

    // 1: reset values, then a single push visible next cycle
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    check("t1_rst_count", 64'(bus.count), 64'd0);
    check("t1_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t1_rst_insn",  64'(bus.out_instruction), 64'hD503201F);
    check("t1_rst_pc",    bus.out_pc, 64'h0);
    check("t1_rst_stall", 64'(bus.fetch_stall), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h91000421, 64'h0, 1'b0);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_insn",  64'(bus.out_instruction), 64'h91000421);
    check("t1_link",  bus.out_pc_link, 64'h4);
    check("t1_count", 64'(bus.count), 64'd1);

    // 2: fill to four entries, fifth push dropped
    for (int i = 1; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b1, 32'h8B000000 + 32'(i), 64'(4 * i), 1'b0);
    check("t2_count", 64'(bus.count), 64'd4);
    check("t2_stall", 64'(bus.fetch_stall), 64'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h8B0000FF, 64'h10, 1'b0);
    check("t2_drop_count", 64'(bus.count), 64'd4);
    check("t2_head_pc",    bus.out_pc, 64'h0);

    // 3: pop and push together while full; push ignored on the full cycle
    cycle(1'b0, 1'b0, 1'b1, 32'hAA000000, 64'h10, 1'b1);
    check("t3_first_pop_pc", bus.out_pc, 64'h4);
    check("t3_first_count",  64'(bus.count), 64'd3);
    for (int i = 1; i < 8; i++)
      cycle(1'b0, 1'b0, 1'b1, 32'hAA000000 + 32'(i), 64'h10 + 64'(4 * i), 1'b1);
    check("t3_count", 64'(bus.count), 64'd3);

    // 4: drain, then push with out_ready at empty
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
    check("t4_empty", 64'(bus.count), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'hD2800020, 64'h200, 1'b1);
    check("t4_valid", 64'(bus.out_valid), 64'd1);
    check("t4_count", 64'(bus.count), 64'd1);
    check("t4_pc",    bus.out_pc, 64'h200);

    // 5: flush at count=3 discards the concurrent push
    cycle(1'b0, 1'b0, 1'b1, 32'h11111111, 64'h204, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h22222222, 64'h208, 1'b0);
    check("t5_pre_count", 64'(bus.count), 64'd3);
    cycle(1'b0, 1'b1, 1'b1, 32'h33333333, 64'h20C, 1'b0);
    check("t5_count", 64'(bus.count), 64'd0);
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_insn",  64'(bus.out_instruction), 64'hD503201F);
    check("t5_stall", 64'(bus.fetch_stall), 64'd0);

    // 6: reset mid-stream at count=2, then new head
    cycle(1'b0, 1'b0, 1'b1, 32'h44444444, 64'h300, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h55555555, 64'h304, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h66666666, 64'h308, 1'b0);
    check("t6_count", 64'(bus.count), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_pc",    bus.out_pc, 64'h0);
    check("t6_link",  bus.out_pc_link, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h77777777, 64'h100, 1'b0);
    check("t6_head_pc", bus.out_pc, 64'h100);
    check("t6_head_link", bus.out_pc_link, 64'h104);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), 32'($urandom),
            {32'($urandom), 32'($urandom)}, ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
